second_player: RTL and testbench

Position/health tracker for the right-hand fighter: the opposite end of the player-1 tracker, consuming player 1's action and position and producing player 2's position and health. It sits beside the player-1 block in the game core, sampling both controllers' 3-bit action codes once per clock. It adds jump immunity, hit-stun lockout and a sticky knockout state.

---
 rtl/second_player.sv | 56 +++++
 tb/tb_second_player.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/second_player.sv
// second_player: right-hand fighter position/health tracker with jump immunity, hit-stun and sticky knockout
module second_player (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] action2,
  input  logic [2:0] action1,
  input  logic [2:0] state1,
  output logic [2:0] state2,
  output logic [1:0] health2,
  output logic       stunned,
  output logic       airborne,
  output logic       ko
);
  localparam logic [2:0] KICK = 3'b000, PUNCH = 3'b001, AWAIT = 3'b010, JUMP = 3'b011;
  typedef enum logic {FIGHT, KNOCKOUT} st_t;
  st_t st, st_n;
  logic [1:0] pos, pos_n, hp_n, air, air_n, stun, stun_n, dmg, i1;
  logic [2:0] r, ea;
  logic clash;
  assign stunned  = stun != 2'd0;
  assign airborne = air != 2'd0;
  assign ko       = st == KNOCKOUT;
  assign state2   = pos == 2'd0 ? 3'b001 : pos == 2'd1 ? 3'b010 : 3'b100;
  always_comb begin
    i1 = state1 == 3'b010 ? 2'd1 : state1 == 3'b001 ? 2'd2 : 2'd0;
    r = {1'b0, i1} + {1'b0, pos};
    dmg = (action1 == KICK && r >= 3'd3 && !airborne) ? 2'd1 :
          (action1 == PUNCH && r == 3'd4) ? 2'd2 : 2'd0;
    hp_n = dmg >= health2 ? 2'd0 : health2 - dmg;
    ea = (stunned || dmg != 2'd0) ? AWAIT : action2;
    // Mirrored kick/punch at full reach knocks us back to index 1 unless we were hit
    clash = r == 3'd4 && action1 == action2 && (action1 == KICK || action1 == PUNCH) && dmg == 2'd0;
    pos_n = clash ? 2'd1 :
            airborne ? pos :
            ea[2:1] == 2'b10 ? (pos == 2'd2 ? 2'd2 : pos + 2'd1) :
            ea[2:1] == 2'b11 ? (pos == 2'd0 ? 2'd0 : pos - 2'd1) : pos;
    air_n = (ea == JUMP && air == 2'd0) ? 2'd2 : air == 2'd0 ? 2'd0 : air - 2'd1;
    stun_n = dmg != 2'd0 ? 2'd2 : stun == 2'd0 ? 2'd0 : stun - 2'd1;
    st_n = (st == KNOCKOUT || hp_n == 2'd0) ? KNOCKOUT : FIGHT;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= FIGHT;
      pos     <= 2'd0;
      health2 <= 2'd3;
      air     <= 2'd0;
      stun    <= 2'd0;
    end else if (st == FIGHT) begin
      st      <= st_n;
      pos     <= pos_n;
      health2 <= hp_n;
      air     <= air_n;
      stun    <= stun_n;
    end
  end
endmodule

// File: tb/tb_second_player.sv
// tb_second_player: randomized and directed checks of second_player against a rule-level model
module tb_second_player;
  logic clk = 0, reset = 0;
  logic [2:0] action2 = 3'b010, action1 = 3'b010, state1 = 3'b100;
  logic [2:0] state2;
  logic [1:0] health2;
  logic stunned, airborne, ko;
  int n_tests = 0, n_fail = 0;
  int m_i2, m_hp, m_air, m_stun;
  bit m_ko;

  second_player dut (.clk(clk), .reset(reset), .action2(action2), .action1(action1), .state1(state1),
                     .state2(state2), .health2(health2), .stunned(stunned), .airborne(airborne), .ko(ko));

  always #5 clk = ~clk;

  function automatic logic [7:0] expv();
    logic [2:0] oh;
    oh = m_i2 == 0 ? 3'b001 : m_i2 == 1 ? 3'b010 : 3'b100;
    return {oh, m_hp[1:0], m_stun != 0, m_air != 0, m_ko};
  endfunction

  function automatic logic [7:0] dutv();
    return {state2, health2, stunned, airborne, ko};
  endfunction

  task automatic model_reset();
    m_i2 = 0; m_hp = 3; m_air = 0; m_stun = 0; m_ko = 0;
  endtask

  task automatic model_step(input logic [2:0] a2, input logic [2:0] a1, input logic [2:0] s1);
    int i1, r, dmg, ea, nhp;
    bit hit_clash, up;
    if (m_ko) return;
    i1 = s1 == 3'b100 ? 0 : s1 == 3'b010 ? 1 : s1 == 3'b001 ? 2 : 0;
    r = i1 + m_i2;
    up = m_air > 0;
    if (a1 == 0 && r >= 3 && !up) dmg = 1;
    else if (a1 == 1 && r == 4) dmg = 2;
    else dmg = 0;
    nhp = m_hp - dmg < 0 ? 0 : m_hp - dmg;
    ea = (m_stun > 0 || dmg > 0) ? 2 : int'(a2);
    hit_clash = r == 4 && a1 == a2 && a1 <= 1 && dmg == 0;
    if (hit_clash) m_i2 = 1;
    else if (!up && (ea == 4 || ea == 5)) m_i2 = m_i2 + 1 > 2 ? 2 : m_i2 + 1;
    else if (!up && (ea == 6 || ea == 7)) m_i2 = m_i2 - 1 < 0 ? 0 : m_i2 - 1;
    m_air = (ea == 3 && !up) ? 2 : (up ? m_air - 1 : 0);
    m_stun = dmg > 0 ? 2 : (m_stun > 0 ? m_stun - 1 : 0);
    m_hp = nhp;
    m_ko = nhp == 0;
  endtask

  task automatic cycle(input logic [2:0] a2, input logic [2:0] a1, input logic [2:0] s1);
    action2 = a2; action1 = a1; state1 = s1;
    model_step(a2, a1, s1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (dutv() !== 8'b001_11_0_0_0)
      begin n_fail++; $display("FAIL reset: got %b want %b", dutv(), 8'b001_11_0_0_0); end
  endtask

  task automatic test_move();
    logic [2:0] want [3] = '{3'b010, 3'b100, 3'b100};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(3'b100, 3'b010, 3'b100);
      n_tests++;
      if (state2 !== want[i] || health2 !== 2'b11 || dutv() !== expv())
        begin n_fail++; $display("FAIL move%0d: got %b want state2 %b model %b", i, dutv(), want[i], expv()); end
    end
  endtask

  task automatic test_stun();
    do_reset();
    cycle(3'b100, 3'b010, 3'b100);
    cycle(3'b100, 3'b010, 3'b100);
    cycle(3'b010, 3'b000, 3'b010);
    n_tests++;
    if (health2 !== 2'b10 || stunned !== 1'b1 || dutv() !== expv())
      begin n_fail++; $display("FAIL stun_hit: got %b model %b", dutv(), expv()); end
    for (int i = 0; i < 2; i++) begin
      cycle(3'b110, 3'b010, 3'b010);
      n_tests++;
      if (state2 !== 3'b100 || stunned !== (i == 0) || dutv() !== expv())
        begin n_fail++; $display("FAIL stun_hold%0d: got %b model %b", i, dutv(), expv()); end
    end
    cycle(3'b110, 3'b010, 3'b010);
    n_tests++;
    if (state2 !== 3'b010 || dutv() !== expv())
      begin n_fail++; $display("FAIL stun_release: got %b model %b", dutv(), expv()); end
  endtask

  task automatic test_jump();
    do_reset();
    cycle(3'b100, 3'b010, 3'b010);
    cycle(3'b100, 3'b010, 3'b010);
    cycle(3'b011, 3'b010, 3'b010);
    n_tests++;
    if (airborne !== 1'b1 || dutv() !== expv())
      begin n_fail++; $display("FAIL jump_up: got %b model %b", dutv(), expv()); end
    for (int i = 0; i < 2; i++) begin
      cycle(3'b010, 3'b000, 3'b010);
      n_tests++;
      if (health2 !== 2'b11 || dutv() !== expv())
        begin n_fail++; $display("FAIL jump_immune%0d: got %b model %b", i, dutv(), expv()); end
    end
    cycle(3'b010, 3'b000, 3'b010);
    n_tests++;
    if (health2 !== 2'b10 || airborne !== 1'b0 || dutv() !== expv())
      begin n_fail++; $display("FAIL jump_land: got %b model %b", dutv(), expv()); end
  endtask

  task automatic test_ko();
    do_reset();
    cycle(3'b100, 3'b010, 3'b100);
    cycle(3'b100, 3'b010, 3'b100);
    cycle(3'b010, 3'b000, 3'b010);
    cycle(3'b010, 3'b000, 3'b010);
    n_tests++;
    if (health2 !== 2'b01 || dutv() !== expv())
      begin n_fail++; $display("FAIL ko_setup: got %b model %b", dutv(), expv()); end
    cycle(3'b010, 3'b001, 3'b001);
    n_tests++;
    if (health2 !== 2'b00 || ko !== 1'b1 || dutv() !== expv())
      begin n_fail++; $display("FAIL ko_edge: got %b model %b", dutv(), expv()); end
    for (int i = 0; i < 4; i++) begin
      cycle(i[0] ? 3'b110 : 3'b011, 3'b000, 3'b010);
      n_tests++;
      if (ko !== 1'b1 || state2 !== 3'b100 || health2 !== 2'b00 || dutv() !== expv())
        begin n_fail++; $display("FAIL ko_frozen%0d: got %b model %b", i, dutv(), expv()); end
    end
  endtask

  task automatic test_clash();
    do_reset();
    cycle(3'b100, 3'b010, 3'b001);
    cycle(3'b100, 3'b010, 3'b001);
    cycle(3'b011, 3'b010, 3'b001);
    cycle(3'b000, 3'b000, 3'b001);
    n_tests++;
    if (state2 !== 3'b010 || health2 !== 2'b11 || dutv() !== expv())
      begin n_fail++; $display("FAIL clash: got %b model %b", dutv(), expv()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(3'b100, 3'b010, 3'b001);
    cycle(3'b100, 3'b010, 3'b001);
    cycle(3'b011, 3'b010, 3'b001);
    cycle(3'b010, 3'b001, 3'b001);
    n_tests++;
    if (stunned !== 1'b1 || airborne !== 1'b1 || health2 !== 2'b01 || dutv() !== expv())
      begin n_fail++; $display("FAIL areset_setup: got %b model %b", dutv(), expv()); end
    #2 reset = 1;
    #1;
    model_reset();
    n_tests++;
    if (dutv() !== 8'b001_11_0_0_0)
      begin n_fail++; $display("FAIL areset_clear: got %b want %b", dutv(), 8'b001_11_0_0_0); end
    #1 reset = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [2:0] s1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      s1 = ($urandom_range(0, 15) == 0) ? 3'($urandom) : (3'b001 << $urandom_range(0, 2));
      cycle(3'($urandom), 3'($urandom), s1);
      n_tests++;
      if (dutv() !== expv())
        begin n_fail++; $display("FAIL random%0d: got %b model %b", i, dutv(), expv()); end
      if (m_ko && $urandom_range(0, 3) == 0) do_reset();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_move();
    test_stun();
    test_jump();
    test_ko();
    test_clash();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
